// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_WIDTH      = 16;
  localparam int unsigned WORD_WIDTH     = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects little-endian payload bytes into one instruction word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  byte_en_i,
  input  logic [7:0]            byte_i,
  output logic [WORD_WIDTH-1:0] word_c,
  output logic                  word_ready_c
);

  localparam int unsigned IDX_WIDTH = $clog2(BYTES_PER_WORD);

  logic [IDX_WIDTH-1:0]  byte_idx;
  logic [WORD_WIDTH-1:0] word_q;

  // Byte index wraps naturally after the last byte of a word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (clear_i) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (byte_en_i) begin
      word_q[8*byte_idx +: 8] <= byte_i;
      byte_idx                <= byte_idx + IDX_WIDTH'(1);
    end
  end

  // Word including the byte being accepted this cycle, so the top can register it directly.
  always_comb begin
    word_c                  = word_q;
    word_c[8*byte_idx +: 8] = byte_i;
  end

  assign word_ready_c = byte_en_i && (byte_idx == IDX_WIDTH'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction-memory writes, checksum check, core reset release.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter int unsigned         ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned         MAX_WORDS   = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic                   imem_we_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  output logic [INSTR_WIDTH-1:0] imem_wdata_o,
  output logic                   cpu_rst_o,
  output logic                   done_o,
  output logic                   err_o
);

  state_t                state, state_c;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  len_full_c;
  logic [LEN_WIDTH-1:0]  word_idx;
  logic [7:0]            checksum;
  logic                  xfer_c;
  logic                  start_c;
  logic                  payload_xfer_c;
  logic                  word_ready_c;
  logic [WORD_WIDTH-1:0] word_c;

  assign xfer_c         = byte_valid_i && byte_ready_o;
  assign start_c        = start_i && (state inside {IDLE, DONE, ERROR});
  assign payload_xfer_c = xfer_c && (state == PAYLOAD);
  assign len_full_c     = {byte_i, len[7:0]};

  word_assembler u_word_assembler (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (start_c),
    .byte_en_i   (payload_xfer_c),
    .byte_i      (byte_i),
    .word_c      (word_c),
    .word_ready_c(word_ready_c)
  );

  // Next-state selection.
  always_comb begin
    state_c = state;
    unique case (state)
      IDLE, DONE, ERROR: if (start_c) state_c = LEN0;
      LEN0:              if (xfer_c) state_c = LEN1;
      LEN1: begin
        if (xfer_c) begin
          if (32'(len_full_c) > MAX_WORDS)     state_c = ERROR;
          else if (len_full_c == '0)           state_c = CHECK;
          else                                 state_c = PAYLOAD;
        end
      end
      PAYLOAD: if (word_ready_c && (word_idx == len - LEN_WIDTH'(1))) state_c = CHECK;
      CHECK:   if (xfer_c) state_c = (byte_i == checksum) ? DONE : ERROR;
      default: state_c = IDLE;
    endcase
  end

  // State, datapath and registered outputs all derive from the chosen next state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      len          <= '0;
      word_idx     <= '0;
      checksum     <= '0;
      byte_ready_o <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      cpu_rst_o    <= 1'b1;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state        <= state_c;
      byte_ready_o <= state_c inside {LEN0, LEN1, PAYLOAD, CHECK};
      done_o       <= (state_c == DONE);
      err_o        <= (state_c == ERROR);
      cpu_rst_o    <= (state_c != DONE);
      imem_we_o    <= word_ready_c;

      if (start_c) begin
        word_idx <= '0;
        checksum <= '0;
      end

      if (xfer_c && state == LEN0) len[7:0]  <= byte_i;
      if (xfer_c && state == LEN1) len[15:8] <= byte_i;
      if (payload_xfer_c)          checksum  <= checksum ^ byte_i;

      if (word_ready_c) begin
        imem_addr_o  <= BASE_ADDR + ADDR_WIDTH'(BYTES_PER_WORD) * ADDR_WIDTH'(word_idx);
        imem_wdata_o <= INSTR_WIDTH'(word_c);
        word_idx     <= word_idx + LEN_WIDTH'(1);
      end
    end
  end

endmodule
